// File: rtl/fp_adder_core.sv
// Single-cycle floating-point adder/subtractor with registered result and overflow/underflow flags.
// Build option: define FPA_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate.
module fp_adder_core #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   b_in,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   fpa_out,
  output logic                                overflow_out,
  output logic                                underflow_out
);

  localparam int W   = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int EW  = EXP_WIDTH;
  localparam int MW  = MANTISSA_WIDTH;
  localparam int SW  = MW + 4;
  localparam int LZW = $clog2(SW + 1);
  localparam int XW  = ((EW > LZW) ? EW : LZW) + 2;
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);

`ifdef FPA_ROUND_NEAREST_EN
  localparam bit ROUND_NEAREST = 1'b1;
`else
  localparam bit ROUND_NEAREST = 1'b0;
`endif

  // Right-align the smaller significand; everything pushed past the round bit folds into sticky.
  function automatic logic [SW-1:0] align_small(input logic [SW-1:0] ext,
                                                input logic [EW-1:0] shamt);
    logic [SW-1:0] shifted;
    logic [SW-1:0] lost_mask;
    logic [SW-1:0] res;
    if (int'(shamt) >= MW + 3) begin
      res = {{(SW-1){1'b0}}, |ext};
    end else begin
      shifted   = ext >> shamt;
      lost_mask = ~({SW{1'b1}} << shamt);
      res       = {shifted[SW-1:1], shifted[0] | (|(ext & lost_mask))};
    end
    return res;
  endfunction

  function automatic logic [LZW-1:0] count_lz(input logic [SW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + LZW'(1);
      end
    end
    return n;
  endfunction

  // Returns {carry, hidden, fraction}; carry set means the increment rippled out of the MSB.
  function automatic logic [MW+1:0] round_mant(input logic [SW-1:0] norm);
    logic inc;
    inc = ROUND_NEAREST & norm[2] & (norm[3] | norm[1] | norm[0]);
    return {1'b0, norm[SW-1:3]} + {{(MW+1){1'b0}}, inc};
  endfunction

  // Returns {overflow, underflow, word}: zero, saturate-to-max-exponent, flush, or normal pack.
  function automatic logic [W+1:0] pack_result(input logic                 sign,
                                               input logic signed [XW-1:0] exp,
                                               input logic [MW-1:0]        frac,
                                               input logic                 is_zero,
                                               input logic                 neg_zero);
    logic [W+1:0] res;
    if (is_zero)
      res = {2'b00, neg_zero, {(W-1){1'b0}}};
    else if (exp >= EXP_MAX)
      res = {2'b10, sign, {EW{1'b1}}, {MW{1'b0}}};
    else if (exp[XW-1] || (exp == '0))
      res = {2'b01, sign, {(W-1){1'b0}}};
    else
      res = {2'b00, sign, exp[EW-1:0], frac};
    return res;
  endfunction

  logic                 sa, sb, za, zb;
  logic [EW-1:0]        ea, eb;
  logic [MW-1:0]        fa, fb;
  logic [W-2:0]         mag_a, mag_b;
  logic [SW-1:0]        ma_x, mb_x;
  logic                 swap;
  logic                 sl, ss;
  logic [EW-1:0]        el, es, diff;
  logic [SW-1:0]        ml_x, ms_x, al;
  logic                 eff_sub;
  logic [SW:0]          sum;
  logic [LZW-1:0]       lz;
  logic [SW-1:0]        norm;
  logic signed [XW-1:0] el_x, exp_n, exp_r;
  logic [MW+1:0]        rounded;
  logic [MW-1:0]        frac_r;
  logic [W+1:0]         packed_c;

  assign sa = a_in[W-1];
  assign sb = b_in[W-1];
  assign ea = a_in[W-2:MW];
  assign eb = b_in[W-2:MW];
  assign fa = a_in[MW-1:0];
  assign fb = b_in[MW-1:0];
  assign za = (ea == '0);
  assign zb = (eb == '0);

  always_comb begin
    mag_a   = za ? '0 : a_in[W-2:0];
    mag_b   = zb ? '0 : b_in[W-2:0];
    ma_x    = za ? '0 : {1'b1, fa, 3'b000};
    mb_x    = zb ? '0 : {1'b1, fb, 3'b000};
    swap    = (mag_b > mag_a);
    sl      = swap ? sb : sa;
    ss      = swap ? sa : sb;
    el      = swap ? (zb ? '0 : eb) : (za ? '0 : ea);
    es      = swap ? (za ? '0 : ea) : (zb ? '0 : eb);
    ml_x    = swap ? mb_x : ma_x;
    ms_x    = swap ? ma_x : mb_x;
    diff    = el - es;
    al      = align_small(ms_x, diff);
    eff_sub = sl ^ ss;
    sum     = eff_sub ? ({1'b0, ml_x} - {1'b0, al}) : ({1'b0, ml_x} + {1'b0, al});

    el_x = $signed({{(XW-EW){1'b0}}, el});
    lz   = count_lz(sum[SW-1:0]);
    if (sum[SW]) begin
      norm  = {sum[SW:2], sum[1] | sum[0]};
      exp_n = el_x + XW'(1);
    end else begin
      norm  = sum[SW-1:0] << lz;
      exp_n = el_x - $signed({{(XW-LZW){1'b0}}, lz});
    end

    rounded = round_mant(norm);
    if (rounded[MW+1]) begin
      exp_r  = exp_n + XW'(1);
      frac_r = rounded[MW:1];
    end else begin
      exp_r  = exp_n;
      frac_r = rounded[MW-1:0];
    end

    packed_c = pack_result(sl, exp_r, frac_r, (sum == '0), za & zb & sa & sb);
  end

  // ---- stage p1: result register ----
  logic [W-1:0] fpa_p1;
  logic         ovf_p1, unf_p1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fpa_p1 <= '0;
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
    end else begin
      fpa_p1 <= packed_c[W-1:0];
      ovf_p1 <= packed_c[W+1];
      unf_p1 <= packed_c[W];
    end
  end

  assign fpa_out       = fpa_p1;
  assign overflow_out  = ovf_p1;
  assign underflow_out = unf_p1;

endmodule

// File: tb/tb_fp_adder_core.sv
// Directed-vector bench for fp_adder_core (single precision); expectations hand-computed per build.
module tb_fp_adder_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] fpa_out;
  logic        overflow_out;
  logic        underflow_out;

  int n_cmp = 0;
  int n_bad = 0;

  fp_adder_core #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .a_in          (a_in),
    .b_in          (b_in),
    .fpa_out       (fpa_out),
    .overflow_out  (overflow_out),
    .underflow_out (underflow_out)
  );

  always #5 clk = ~clk;

`ifdef FPA_ROUND_NEAREST_EN
  localparam logic [31:0] EXP_ULP34   = 32'h3F800001;
  localparam logic [31:0] EXP_BIG_15  = 32'h4B800001;
  localparam logic [31:0] EXP_ONE_EPS = 32'h3F800000;
  localparam logic [31:0] EXP_RC      = 32'h7F800000;
  localparam logic        EXP_RC_OVF  = 1'b1;
`else
  localparam logic [31:0] EXP_ULP34   = 32'h3F800000;
  localparam logic [31:0] EXP_BIG_15  = 32'h4B800000;
  localparam logic [31:0] EXP_ONE_EPS = 32'h3F7FFFFF;
  localparam logic [31:0] EXP_RC      = 32'h7F7FFFFF;
  localparam logic        EXP_RC_OVF  = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] e_out,
                       input logic e_ovf, input logic e_unf);
    n_cmp++;
    assert (fpa_out === e_out) else begin
      n_bad++;
      $error("FAIL %s fpa_out observed=%h expected=%h", tag, fpa_out, e_out);
    end
    n_cmp++;
    assert (overflow_out === e_ovf) else begin
      n_bad++;
      $error("FAIL %s overflow_out observed=%b expected=%b", tag, overflow_out, e_ovf);
    end
    n_cmp++;
    assert (underflow_out === e_unf) else begin
      n_bad++;
      $error("FAIL %s underflow_out observed=%b expected=%b", tag, underflow_out, e_unf);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b);
    a_in = a;
    b_in = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    step(32'h3F800000, 32'h3F800000);
    check("reset", 32'h00000000, 1'b0, 1'b0);
    step(32'h3F800000, 32'h3F800000);
    check("reset_hold", 32'h00000000, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    step(32'h3F800000, 32'h3F800000); check("one_plus_one", 32'h40000000, 1'b0, 1'b0);
    step(32'h3FC00000, 32'hBFC00000); check("cancel", 32'h00000000, 1'b0, 1'b0);
    step(32'h7F7FFFFF, 32'h7F7FFFFF); check("overflow", 32'h7F800000, 1'b1, 1'b0);
    step(32'h00800001, 32'h80800000); check("underflow", 32'h00000000, 1'b0, 1'b1);
    step(32'h3F800000, 32'h33C00000); check("round_3q_ulp", EXP_ULP34, 1'b0, 1'b0);
    step(32'h80000000, 32'h80000000); check("neg_zero", 32'h80000000, 1'b0, 1'b0);
    step(32'h80000000, 32'h00000000); check("mixed_zero", 32'h00000000, 1'b0, 1'b0);
    step(32'h40000000, 32'hBF000000); check("sub_norm_left", 32'h3FC00000, 1'b0, 1'b0);
    step(32'h3F000000, 32'hC0000000); check("swap_sign", 32'hBFC00000, 1'b0, 1'b0);
    step(32'h00000001, 32'h3F800000); check("denorm_flush", 32'h3F800000, 1'b0, 1'b0);
    step(32'h80000001, 32'h80000005); check("denorm_negzero", 32'h80000000, 1'b0, 1'b0);
    step(32'hC0400000, 32'h00000000); check("plus_zero", 32'hC0400000, 1'b0, 1'b0);
    step(32'h4B800000, 32'h3F800000); check("tie_even", 32'h4B800000, 1'b0, 1'b0);
    step(32'h4B800000, 32'h3FC00000); check("big_plus_1p5", EXP_BIG_15, 1'b0, 1'b0);
    step(32'h3F800000, 32'hA5800000); check("one_minus_tiny", EXP_ONE_EPS, 1'b0, 1'b0);
    step(32'h7F7FFFFF, 32'h73000000); check("round_carry_max", EXP_RC, EXP_RC_OVF, 1'b0);
    step(32'h7E800000, 32'h7E800000); check("near_max", 32'h7F000000, 1'b0, 1'b0);
    step(32'h00800000, 32'h00800000); check("min_normal", 32'h01000000, 1'b0, 1'b0);

    // Back-to-back stream: each check sees the pair applied in the preceding cycle only.
    step(32'h40400000, 32'h3F800000); check("b2b_0", 32'h40800000, 1'b0, 1'b0);
    step(32'hC1200000, 32'h40A00000); check("b2b_1", 32'hC0A00000, 1'b0, 1'b0);
    step(32'h7F7FFFFF, 32'h7F000000); check("b2b_2", 32'h7F800000, 1'b1, 1'b0);
    step(32'h3F800000, 32'h3F800000); check("b2b_3", 32'h40000000, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle clears the in-flight result without a clock edge.
    a_in = 32'h7F7FFFFF;
    b_in = 32'h7F7FFFFF;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 32'h00000000, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(32'h40000000, 32'h40000000);
    check("post_reset", 32'h40800000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
